// File: rtl/demodulator_if.sv
// demodulator_if: host-side bundle for the serial frame demodulator.
//   start              host -> demod  arm request, level-held until done is seen
//   symbol_time        host -> demod  clock cycles per symbol repetition
//   repetition_factor  host -> demod  repetitions per bit
//   wave_enable        host -> demod  frame qualifier, high for the whole frame
//   in                 host -> demod  serial data level
//   out_bitstream      demod -> host  received frame, first bit in MSB
//   done               demod -> host  frame complete (held until start drops)
//   busy               demod -> host  armed or receiving
//   frame_error        demod -> host  frame aborted early (held like done)
interface demodulator_if #(
  parameter int NUM_BITS = 128
);
  logic                start;
  logic [15:0]         symbol_time;
  logic [3:0]          repetition_factor;
  logic                wave_enable;
  logic                in;
  logic [NUM_BITS-1:0] out_bitstream;
  logic                done;
  logic                busy;
  logic                frame_error;

  modport master (
    output start, symbol_time, repetition_factor, wave_enable, in,
    input  out_bitstream, done, busy, frame_error
  );

  modport slave (
    input  start, symbol_time, repetition_factor, wave_enable, in,
    output out_bitstream, done, busy, frame_error
  );
endinterface

// File: rtl/demodulator.sv
// demodulator: recovers a NUM_BITS-bit frame from a serial level stream.
// Each bit arrives MSB first, held for st x rf cycles; every repetition is
// sampled at st>>1 and the repetitions are majority-voted (ties -> 0).
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    demodulator_if.slave (start/config/serial in, frame/done/busy/error out)
// Optional build macro DEMOD_INPUT_SYNC_EN: passes in and wave_enable through
// 2-flop synchronizers first (all timing shifts by 2 cycles).
module demodulator #(
  parameter int NUM_BITS = 128
) (
  input  logic           clk,
  input  logic           reset,
  demodulator_if.slave   bus
);

  localparam int BCW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] RECEIVE  = 2'd2;
  localparam logic [1:0] COMPLETE = 2'd3;

  logic in_s;
  logic we_s;

`ifdef DEMOD_INPUT_SYNC_EN
  logic [1:0] in_sync;
  logic [1:0] we_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_sync <= '0;
      we_sync <= '0;
    end else begin
      in_sync <= {in_sync[0], bus.in};
      we_sync <= {we_sync[0], bus.wave_enable};
    end
  end

  assign in_s = in_sync[1];
  assign we_s = we_sync[1];
`else
  assign in_s = bus.in;
  assign we_s = bus.wave_enable;
`endif

  logic [1:0]          state;
  logic [15:0]         st_q;
  logic [3:0]          rf_q;
  logic [15:0]         sym_cnt;
  logic [3:0]          rep_cnt;
  logic [3:0]          ones_cnt;
  logic [BCW-1:0]      bit_cnt;
  logic [NUM_BITS-1:0] shreg;
  logic [NUM_BITS-1:0] out_q;
  logic                done_q;
  logic                busy_q;
  logic                err_q;

  logic [15:0]         sp;
  logic                sym_last;
  logic                rep_last;
  logic                bit_end;
  logic                last_bit;
  logic [3:0]          ones_next;
  logic                decision;
  logic                active;
  logic [NUM_BITS-1:0] shreg_next;
  logic [BCW:0]        shamt;
  logic [NUM_BITS-1:0] partial;

  always_comb begin
    sp         = st_q >> 1;
    sym_last   = (sym_cnt == st_q - 16'd1);
    rep_last   = (rep_cnt == rf_q - 4'd1);
    bit_end    = sym_last && rep_last;
    last_bit   = (bit_cnt == BCW'(NUM_BITS - 1));
    ones_next  = ones_cnt + {3'b000, (sym_cnt == sp) & in_s};
    decision   = ({ones_next, 1'b0} > {1'b0, rf_q});
    shreg_next = {shreg[NUM_BITS-2:0], decision};
    shamt      = (BCW+1)'(NUM_BITS) - {1'b0, bit_cnt};
    partial    = shreg << shamt;
    // The first wave_enable-high cycle in ARMED is already symbol cycle 0,
    // so it is processed exactly like a RECEIVE cycle.
    active     = we_s && ((state == RECEIVE) || (state == ARMED && bus.start));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      st_q     <= '0;
      rf_q     <= '0;
      sym_cnt  <= '0;
      rep_cnt  <= '0;
      ones_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            st_q     <= (bus.symbol_time == 16'd0) ? 16'd1 : bus.symbol_time;
            rf_q     <= (bus.repetition_factor == 4'd0) ? 4'd1 : bus.repetition_factor;
            sym_cnt  <= '0;
            rep_cnt  <= '0;
            ones_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            busy_q   <= 1'b1;
            state    <= ARMED;
          end
        end
        ARMED: begin
          if (!bus.start) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (we_s) begin
            state <= RECEIVE;
          end
        end
        RECEIVE: begin
          if (!we_s) begin
            out_q  <= partial;
            done_q <= 1'b1;
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= COMPLETE;
          end
        end
        COMPLETE: begin
          if (!bus.start) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Counter step; placed after the case so that completion on the last
      // bit boundary overrides the state chosen above.
      if (active) begin
        sym_cnt <= sym_last ? 16'd0 : sym_cnt + 16'd1;
        if (bit_end) begin
          shreg    <= shreg_next;
          ones_cnt <= '0;
          rep_cnt  <= '0;
          bit_cnt  <= bit_cnt + 1'b1;
          if (last_bit) begin
            out_q  <= shreg_next;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= COMPLETE;
          end
        end else begin
          ones_cnt <= ones_next;
          if (sym_last) rep_cnt <= rep_cnt + 4'd1;
        end
      end
    end
  end

  assign bus.out_bitstream = out_q;
  assign bus.done          = done_q;
  assign bus.busy          = busy_q;
  assign bus.frame_error   = err_q;

endmodule

// File: tb/tb_demodulator.sv
module tb_demodulator;

  localparam int N = 128;
`ifdef DEMOD_INPUT_SYNC_EN
  localparam int unsigned SYNC_LAT = 2;
`else
  localparam int unsigned SYNC_LAT = 0;
`endif

  localparam logic [N-1:0] W1  = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
  localparam logic [N-1:0] W1A = 128'hDEADBEEF_01000000_00000000_00000000;
  localparam logic [N-1:0] W2  = 128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978;
  localparam logic [N-1:0] W2T = 128'h01234567_89ABCDEF_0F1E2D3C_4B5A6958;
  localparam logic [N-1:0] WA  = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
  localparam logic [N-1:0] W3  = 128'h55550000_FFFF1234_80000001_C3C37E7E;

  logic clk;
  logic reset;
  int unsigned cyc;
  int checks;
  int errors;

  typedef struct {
    logic [N-1:0] word;
    logic         err;
    int unsigned  lat;
    int unsigned  we_cyc;
  } exp_t;

  exp_t sb[$];

  demodulator_if #(.NUM_BITS(N)) bus_if ();

  demodulator #(.NUM_BITS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per rising done.
  initial begin : monitor
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.done === 1'b1 && !done_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("frame_word", bus_if.out_bitstream, e.word);
          chk("frame_error", N'(bus_if.frame_error), N'(e.err));
          chk("done_latency", N'(cyc - e.we_cyc), N'(e.lat));
          chk("busy_at_done", N'(bus_if.busy), 0);
        end
      end
      done_prev = (bus_if.done === 1'b1);
    end
  end

  task automatic arm(input logic [15:0] st, input logic [3:0] rf);
    @(negedge clk);
    bus_if.symbol_time       = st;
    bus_if.repetition_factor = rf;
    bus_if.start             = 1'b1;
    @(negedge clk);
    chk("busy_armed", N'(bus_if.busy), 1);
  endtask

  // Modulator model: MSB first, each bit held st*rf cycles; optionally
  // inverts word[cbit] during repetition crep.
  task automatic drive_bits(input logic [N-1:0] word, input int st, input int rf,
                            input int nbits, input int cbit, input int crep,
                            input bit push, input logic [N-1:0] exp_word,
                            input logic exp_err, input int unsigned lat);
    exp_t e;
    bit first;
    logic bitv;
    first = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      for (int r = 0; r < rf; r++) begin
        for (int s = 0; s < st; s++) begin
          @(negedge clk);
          if (first) begin
            first = 1'b0;
            if (push) begin
              e.word = exp_word; e.err = exp_err; e.lat = lat; e.we_cyc = cyc;
              sb.push_back(e);
            end
          end else begin
            // Configuration is latched at arm time; disturb the ports.
            bus_if.symbol_time       = 16'h0013;
            bus_if.repetition_factor = 4'd7;
          end
          bitv = word[N-1-b];
          if (b == N-1-cbit && r == crep) bitv = ~bitv;
          bus_if.wave_enable = 1'b1;
          bus_if.in          = bitv;
        end
      end
    end
  endtask

  task automatic wait_done(input int max);
    int n;
    n = 0;
    while (bus_if.done !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (bus_if.done !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  task automatic release_start();
    @(negedge clk);
    bus_if.wave_enable = 1'b0;
    bus_if.in          = 1'b0;
    bus_if.start       = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_cleared", N'(bus_if.done), 0);
    chk("error_cleared", N'(bus_if.frame_error), 0);
  endtask

  task automatic run_frame(input logic [N-1:0] word, input logic [15:0] st_p,
                           input logic [3:0] rf_p, input int cbit, input int crep,
                           input logic [N-1:0] exp_word);
    int st;
    int rf;
    st = (st_p == 0) ? 1 : int'(st_p);
    rf = (rf_p == 0) ? 1 : int'(rf_p);
    arm(st_p, rf_p);
    drive_bits(word, st, rf, N, cbit, crep, 1'b1, exp_word, 1'b0,
               int'(N) * st * rf + SYNC_LAT);
    @(negedge clk);
    bus_if.wave_enable = 1'b0;
    wait_done(20);
    repeat (2) @(negedge clk);
    release_start();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus_if.start             = 1'b0;
    bus_if.symbol_time       = '0;
    bus_if.repetition_factor = '0;
    bus_if.wave_enable       = 1'b0;
    bus_if.in                = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out", bus_if.out_bitstream, '0);
    chk("reset_done", N'(bus_if.done), 0);
    chk("reset_busy", N'(bus_if.busy), 0);
    chk("reset_error", N'(bus_if.frame_error), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback st=4 rf=1
    run_frame(W1, 16'd4, 4'd1, -1, 0, W1);
    // Majority vote, one bad repetition out of three
    run_frame(W2, 16'd8, 4'd3, 5, 1, W2);
    // Tie with rf=2 resolves to 0
    run_frame(W2, 16'd4, 4'd2, 5, 0, W2T);
    // Degenerate configuration -> st=1 rf=1
    run_frame(WA, 16'd0, 4'd0, -1, 0, WA);

    // Abort after 40 bits
    arm(16'd4, 4'd1);
    drive_bits(W1, 4, 1, 40, -1, 0, 1'b1, W1A, 1'b1, 160 + 1 + SYNC_LAT);
    @(negedge clk);
    bus_if.wave_enable = 1'b0;
    wait_done(20);
    repeat (2) @(negedge clk);
    chk("abort_hold", bus_if.out_bitstream, W1A);
    release_start();
    chk("abort_idle_busy", N'(bus_if.busy), 0);

    // Start held after done; a second wave_enable burst is ignored
    arm(16'd2, 4'd2);
    drive_bits(W3, 2, 2, N, -1, 0, 1'b1, W3, 1'b0, 512 + SYNC_LAT);
    @(negedge clk);
    bus_if.wave_enable = 1'b0;
    wait_done(20);
    repeat (20) begin
      @(negedge clk);
      bus_if.wave_enable = 1'b1;
      bus_if.in          = 1'($urandom);
    end
    @(negedge clk);
    bus_if.wave_enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_done", N'(bus_if.done), 1);
    chk("hold_word", bus_if.out_bitstream, W3);
    chk("hold_error", N'(bus_if.frame_error), 0);
    release_start();
    chk("hold_word_after_idle", bus_if.out_bitstream, W3);

    // Reset at bit 64 of a frame
    arm(16'd2, 4'd1);
    drive_bits(W2, 2, 1, 64, -1, 0, 1'b0, '0, 1'b0, 0);
    @(negedge clk);
    reset              = 1'b1;
    bus_if.wave_enable = 1'b0;
    bus_if.start       = 1'b0;
    @(negedge clk);
    chk("midreset_out", bus_if.out_bitstream, '0);
    chk("midreset_done", N'(bus_if.done), 0);
    chk("midreset_busy", N'(bus_if.busy), 0);
    chk("midreset_error", N'(bus_if.frame_error), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_frame(W1, 16'd3, 4'd1, -1, 0, W1);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", N'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
